ball_serve_ctrl: RTL

- Downstream consumer of the LFSR random generator (`random`, output Q). Decides how every serve is launched.
- On game start, or after a goal, waits a fixed number of frames, then samples the random word once.
- Maps the sample to the ball's start position and initial velocity, and offers the result to the ball motion controller over a valid/ready handshake.

---
 rtl/ball_serve_ctrl_pkg.sv | 27 ++
 rtl/ball_serve_ctrl_if.sv | 31 +++
 rtl/ball_serve_ctrl_map.sv | 38 +++
 rtl/ball_serve_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/ball_serve_ctrl_pkg.sv
// Shared types and screen constants for the pong serve path.
// FSM states, serve directions and coordinate/velocity widths.
package pong_pkg;

  localparam int HOR_RES = 800;
  localparam int VER_RES = 600;
  localparam int COORD_W = 11;
  localparam int VEL_W   = 5;
  localparam int CNT_W   = 7;

  typedef logic [COORD_W-1:0]      coord_t;
  typedef logic signed [VEL_W-1:0] vel_t;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    OFFER,
    PLAY
  } serve_state_t;

  typedef enum logic [1:0] {
    DIR_LEFT,
    DIR_RIGHT,
    DIR_RANDOM
  } serve_dir_t;

endpackage

// File: rtl/ball_serve_ctrl_if.sv
// Serve payload handshake between the serve controller
// and the ball motion controller.
interface serve_if;
  import pong_pkg::*;

  logic   serve_valid;
  logic   serve_ready;
  coord_t ball_x0;
  coord_t ball_y0;
  vel_t   vel_x;
  vel_t   vel_y;

  modport master (
    output serve_valid,
    output ball_x0,
    output ball_y0,
    output vel_x,
    output vel_y,
    input  serve_ready
  );

  modport slave (
    input  serve_valid,
    input  ball_x0,
    input  ball_y0,
    input  vel_x,
    input  vel_y,
    output serve_ready
  );

endinterface

// File: rtl/ball_serve_ctrl_map.sv
// Combinational map of a random word plus serve direction
// to start y and initial velocity.
module serve_param_map
  import pong_pkg::*;
#(
  parameter int RND_W    = 3,
  parameter int Y_BASE   = 188,
  parameter int Y_STEP   = 32,
  parameter int VX_SERVE = 4,
  parameter int VY_MAX   = 3
) (
  input  logic [RND_W-1:0] rnd,
  input  serve_dir_t       dir,
  output coord_t           ball_y0,
  output vel_t             vel_x,
  output vel_t             vel_y
);

  localparam vel_t VX = vel_t'(VX_SERVE);

  int mag;

  always_comb begin
    ball_y0 = coord_t'(Y_BASE + int'(rnd) * Y_STEP);
    // a zero magnitude would give a flat serve; force a slope
    mag = int'(rnd[RND_W-1:1]);
    if (mag == 0) mag = 1;
    if (mag > VY_MAX) mag = VY_MAX;
    vel_y = rnd[0] ? -vel_t'(mag) : vel_t'(mag);
    vel_x = -VX;
    unique case (dir)
      DIR_LEFT:  vel_x = -VX;
      DIR_RIGHT: vel_x = VX;
      default:   vel_x = rnd[RND_W-1] ? VX : -VX;
    endcase
  end

endmodule

// File: rtl/ball_serve_ctrl.sv
// Serve controller: waits SERVE_DELAY frames after a start or goal,
// samples the random word once and offers the serve payload.
module ball_serve_ctrl
  import pong_pkg::*;
#(
  parameter int RND_W       = 3,
  parameter int SERVE_DELAY = 60,
  parameter int BALL_X0     = 400,
  parameter int Y_BASE      = 188,
  parameter int Y_STEP      = 32,
  parameter int VX_SERVE    = 4,
  parameter int VY_MAX      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             game_start,
  input  logic             goal_left,
  input  logic             goal_right,
  input  logic [RND_W-1:0] rnd,
  serve_if.master          sif,
  output logic             serving,
  output logic [CNT_W-1:0] countdown
);

  localparam coord_t Y_MID =
    coord_t'(Y_BASE + ((2**RND_W - 1) * Y_STEP) / 2);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(SERVE_DELAY);

  serve_state_t     state, state_n;
  serve_dir_t       dir;
  logic [CNT_W-1:0] cnt;
  coord_t           y0_q, map_y0;
  vel_t             vx_q, vy_q, map_vx, map_vy;
  logic             load, sample, last_tick;

  serve_param_map #(
    .RND_W    (RND_W),
    .Y_BASE   (Y_BASE),
    .Y_STEP   (Y_STEP),
    .VX_SERVE (VX_SERVE),
    .VY_MAX   (VY_MAX)
  ) u_map (
    .rnd     (rnd),
    .dir     (dir),
    .ball_y0 (map_y0),
    .vel_x   (map_vx),
    .vel_y   (map_vy)
  );

  assign last_tick = frame_tick && (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (game_start) begin
      state_n = DELAY;
    end else begin
      unique case (state)
        IDLE:  state_n = IDLE;
        DELAY: if (last_tick) state_n = OFFER;
        OFFER: if (sif.serve_ready) state_n = PLAY;
        PLAY:  if (goal_left || goal_right)
                 state_n = DELAY;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    sif.serve_valid = (state == OFFER);
    serving   = (state == DELAY) || (state == OFFER);
    countdown = (state == DELAY) ? cnt : '0;
  end

  // game_start reloads even when already counting down
  assign load = game_start ||
                (state == PLAY && (goal_left || goal_right));
  assign sample = !game_start && state == DELAY && last_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      dir <= DIR_RANDOM;
    end else begin
      if (load)
        cnt <= CNT_LOAD;
      else if (state == DELAY && frame_tick)
        cnt <= cnt - CNT_W'(1);
      if (game_start)
        dir <= DIR_RANDOM;
      else if (state == PLAY && goal_left)
        dir <= DIR_LEFT;
      else if (state == PLAY && goal_right)
        dir <= DIR_RIGHT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y0_q <= Y_MID;
      vx_q <= '0;
      vy_q <= '0;
    end else if (sample) begin
      y0_q <= map_y0;
      vx_q <= map_vx;
      vy_q <= map_vy;
    end
  end

  assign sif.ball_x0 = coord_t'(BALL_X0);
  assign sif.ball_y0 = y0_q;
  assign sif.vel_x   = vx_q;
  assign sif.vel_y   = vy_q;

endmodule
